// File: rtl/spi_pkg.sv
// Shared types and helpers for the SPI register bank: FSM states,
// R/W bit encodings and the frame-width calculation.
package spi_pkg;

    typedef enum logic [2:0] {
        IDLE,
        HDR,
        WDATA,
        RDATA,
        DONE
    } spi_state_t;

    localparam logic WR = 1'b1;
    localparam logic RD = 1'b0;

    function automatic int frame_width(input int addr_w, input int data_w);
        return 1 + addr_w + data_w;
    endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-stage synchroniser for an asynchronous pin with registered
// rise/fall pulses; level is delayed so it lines up with the pulses.
module spi_sync_edge #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync_q;
    logic              prev_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
            prev_q <= 1'b0;
            rise   <= 1'b0;
            fall   <= 1'b0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], din};
            prev_q <= sync_q[STAGES-1];
            rise   <= sync_q[STAGES-1] & ~prev_q;
            fall   <= ~sync_q[STAGES-1] & prev_q;
        end
    end

    assign level = prev_q;

endmodule

// File: rtl/spi_reg_bank.sv
// SPI mode-0 peripheral exposing a NUM_REGS x DATA_W register bank with
// write-back, read-back over cipo, per-register write strobes and error pulses.
module spi_reg_bank
    import spi_pkg::*;
#(
    parameter int NUM_REGS    = 5,
    parameter int DATA_W      = 8,
    parameter int ADDR_W      = 7,
    parameter int SYNC_STAGES = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       sclk,
    input  logic                       copi,
    input  logic                       ncs,
    output logic                       cipo,
    output logic                       cipo_oe,
    output logic [NUM_REGS*DATA_W-1:0] regs,
    output logic [NUM_REGS-1:0]        wr_stb,
    output logic                       frame_err,
    output logic                       addr_err
);

    localparam int FRAME_W = frame_width(ADDR_W, DATA_W);
    localparam int CNT_W   = $clog2(FRAME_W + 1);
    localparam logic [ADDR_W:0] NUM_REGS_A = (ADDR_W + 1)'(NUM_REGS);

    logic sclk_lvl, sclk_rise_raw, sclk_fall_raw;
    logic copi_lvl, copi_rise, copi_fall;
    logic ncs_lvl, ncs_rise, ncs_fall;
    logic unused_sync;

    spi_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_sclk (
        .clk(clk), .rst(rst), .din(sclk),
        .level(sclk_lvl), .rise(sclk_rise_raw), .fall(sclk_fall_raw)
    );
    spi_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_copi (
        .clk(clk), .rst(rst), .din(copi),
        .level(copi_lvl), .rise(copi_rise), .fall(copi_fall)
    );
    spi_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_ncs (
        .clk(clk), .rst(rst), .din(ncs),
        .level(ncs_lvl), .rise(ncs_rise), .fall(ncs_fall)
    );

    assign unused_sync = ^{sclk_lvl, copi_rise, copi_fall};

    // sclk activity only counts while the chip is selected
    logic sclk_rise, sclk_fall;
    assign sclk_rise = sclk_rise_raw & ~ncs_lvl;
    assign sclk_fall = sclk_fall_raw & ~ncs_lvl;

    spi_state_t          state, state_next;
    logic [CNT_W-1:0]    bit_cnt;
    logic [FRAME_W-1:0]  shift_in;
    logic [FRAME_W-1:0]  shift_next;
    logic [DATA_W-1:0]   shift_out;
    logic [DATA_W-1:0]   rd_word;
    logic [ADDR_W-1:0]   hdr_addr;
    logic                hdr_rw;
    logic                overrun;
    logic [DATA_W-1:0]   bank [NUM_REGS];

    logic                rw_now;
    logic [ADDR_W-1:0]   addr_now;
    logic                hdr_addr_ok;

    assign shift_next  = {shift_in[FRAME_W-2:0], copi_lvl};
    assign rw_now      = shift_next[ADDR_W];
    assign addr_now    = shift_next[ADDR_W-1:0];
    assign hdr_addr_ok = ({1'b0, hdr_addr} < NUM_REGS_A);

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
        assign regs[g*DATA_W +: DATA_W] = bank[g];
    end

    always_comb begin
        rd_word = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (addr_now == ADDR_W'(i)) begin
                rd_word = bank[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Priority: ncs edges override sclk edges arriving in the same cycle
    always_comb begin
        state_next = state;
        if (ncs_fall) begin
            state_next = HDR;
        end else if (ncs_rise) begin
            state_next = IDLE;
        end else if (sclk_rise) begin
            case (state)
                HDR: begin
                    if (bit_cnt == CNT_W'(ADDR_W)) begin
                        state_next = (rw_now == WR) ? WDATA : RDATA;
                    end
                end
                WDATA, RDATA: begin
                    if (bit_cnt == CNT_W'(FRAME_W - 1)) begin
                        state_next = DONE;
                    end
                end
                default: state_next = state;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bit_cnt   <= '0;
            shift_in  <= '0;
            shift_out <= '0;
            hdr_addr  <= '0;
            hdr_rw    <= RD;
            overrun   <= 1'b0;
            cipo      <= 1'b0;
            cipo_oe   <= 1'b0;
            wr_stb    <= '0;
            frame_err <= 1'b0;
            addr_err  <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) begin
                bank[i] <= '0;
            end
        end else begin
            wr_stb    <= '0;
            frame_err <= 1'b0;
            addr_err  <= 1'b0;
            if (ncs_fall) begin
                bit_cnt  <= '0;
                shift_in <= '0;
                overrun  <= 1'b0;
                cipo     <= 1'b0;
                cipo_oe  <= 1'b0;
            end else if (ncs_rise) begin
                cipo    <= 1'b0;
                cipo_oe <= 1'b0;
                if (state != IDLE) begin
                    if (state == DONE && !overrun) begin
                        if (!hdr_addr_ok) begin
                            addr_err <= 1'b1;
                        end else if (hdr_rw == WR) begin
                            for (int i = 0; i < NUM_REGS; i++) begin
                                if (hdr_addr == ADDR_W'(i)) begin
                                    bank[i]   <= shift_in[DATA_W-1:0];
                                    wr_stb[i] <= 1'b1;
                                end
                            end
                        end
                    end else begin
                        frame_err <= 1'b1;
                    end
                end
            end else begin
                if (sclk_rise) begin
                    case (state)
                        HDR: begin
                            shift_in <= shift_next;
                            bit_cnt  <= bit_cnt + CNT_W'(1);
                            if (bit_cnt == CNT_W'(ADDR_W)) begin
                                hdr_rw   <= rw_now;
                                hdr_addr <= addr_now;
                                if (rw_now == RD) begin
                                    shift_out <= rd_word;
                                    cipo_oe   <= 1'b1;
                                end
                            end
                        end
                        WDATA, RDATA: begin
                            shift_in <= shift_next;
                            bit_cnt  <= bit_cnt + CNT_W'(1);
                        end
                        DONE:    overrun <= 1'b1;
                        default: ;
                    endcase
                end
                if (sclk_fall && state == RDATA) begin
                    cipo      <= shift_out[DATA_W-1];
                    shift_out <= {shift_out[DATA_W-2:0], 1'b0};
                end
            end
        end
    end

endmodule

// File: tb/tb_spi_reg_bank.sv
// Directed bench for spi_reg_bank: a default instance and a 16x16 instance,
// with expectations queued from a bench-side register model.
module tb_spi_reg_bank;

    logic clk = 1'b0;
    logic rst, sclk, copi, ncs0, ncs1;

    logic          cipo0, oe0, fe0, ae0;
    logic [39:0]   regs0;
    logic [4:0]    wr0;
    logic          cipo1, oe1, fe1, ae1;
    logic [255:0]  regs1;
    logic [15:0]   wr1;

    always #5 clk = ~clk;

    spi_reg_bank dut0 (
        .clk(clk), .rst(rst), .sclk(sclk), .copi(copi), .ncs(ncs0),
        .cipo(cipo0), .cipo_oe(oe0), .regs(regs0), .wr_stb(wr0),
        .frame_err(fe0), .addr_err(ae0)
    );

    spi_reg_bank #(.NUM_REGS(16), .DATA_W(16), .ADDR_W(4), .SYNC_STAGES(2)) dut1 (
        .clk(clk), .rst(rst), .sclk(sclk), .copi(copi), .ncs(ncs1),
        .cipo(cipo1), .cipo_oe(oe1), .regs(regs1), .wr_stb(wr1),
        .frame_err(fe1), .addr_err(ae1)
    );

    int total = 0;
    int bad   = 0;
    logic [255:0] exp_q[$];

    logic [7:0]  m0 [5];
    logic [15:0] m1_15;

    // Pulse monitors: cycles with any strobe high and error pulse counts
    int wr_cyc0 = 0, ae_cnt0 = 0, fe_cnt0 = 0;
    int wr_cyc1 = 0, ae_cnt1 = 0, fe_cnt1 = 0;
    logic [4:0]  wr_last0 = '0;
    logic [15:0] wr_last1 = '0;

    always @(negedge clk) begin
        if (wr0 != 0) begin wr_cyc0++; wr_last0 = wr0; end
        if (ae0) ae_cnt0++;
        if (fe0) fe_cnt0++;
        if (wr1 != 0) begin wr_cyc1++; wr_last1 = wr1; end
        if (ae1) ae_cnt1++;
        if (fe1) fe_cnt1++;
    end

    initial begin
        #2ms;
        $display("[TB] FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [39:0] flat0();
        return {m0[4], m0[3], m0[2], m0[1], m0[0]};
    endfunction

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic push_exp(input logic [255:0] v);
        exp_q.push_back(v);
    endtask

    task automatic check_output(input string tag, input logic [255:0] obs);
        logic [255:0] e;
        if (exp_q.size() == 0) begin
            total++;
            bad++;
            $error("[TB] FAIL %s: observed=%0h expected=<empty queue>", tag, obs);
        end else begin
            e = exp_q.pop_front();
            check(tag, obs, e);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drops ncs and shifts nbits of word (fw bits wide, MSB first); cipo and
    // cipo_oe are sampled just before each rising sclk edge
    task automatic apply_stimulus(input bit sel, input logic [31:0] word, input int fw,
                                  input int nbits, input int hdr_len,
                                  output logic [31:0] rx, output int oe_data, output int oe_hdr);
        logic oe;
        rx = '0; oe_data = 0; oe_hdr = 0;
        if (sel) ncs1 = 1'b0; else ncs0 = 1'b0;
        wait_clk(8);
        for (int i = 0; i < nbits; i++) begin
            copi = (i < fw) ? word[fw-1-i] : 1'b0;
            wait_clk(8);
            oe = sel ? oe1 : oe0;
            if (i >= hdr_len) begin
                rx = {rx[30:0], sel ? cipo1 : cipo0};
                if (oe) oe_data++;
            end else if (oe) begin
                oe_hdr++;
            end
            sclk = 1'b1;
            wait_clk(8);
            sclk = 1'b0;
        end
        wait_clk(8);
    endtask

    task automatic end_frame(input bit sel);
        if (sel) ncs1 = 1'b1; else ncs0 = 1'b1;
        wait_clk(12);
    endtask

    logic [31:0] rx;
    int oe_d, oe_h;

    initial begin
        rst = 1'b1; sclk = 1'b0; copi = 1'b0; ncs0 = 1'b1; ncs1 = 1'b1;
        for (int i = 0; i < 5; i++) m0[i] = '0;
        m1_15 = '0;
        wait_clk(5);
        rst = 1'b0;
        wait_clk(6);

        check("rst_regs0", regs0, '0);
        check("rst_regs1", regs1, '0);
        check("rst_cipo", {cipo0, oe0, cipo1, oe1}, '0);
        check("rst_pulses", {wr0, fe0, ae0, wr1, fe1, ae1}, '0);

        // write 0xA5 to addr 1
        m0[1] = 8'hA5;
        push_exp(flat0());
        apply_stimulus(0, 32'h81A5, 16, 16, 8, rx, oe_d, oe_h);
        end_frame(0);
        check_output("wr1_regs", regs0);
        check("wr1_stb_cycles", wr_cyc0, 1);
        check("wr1_stb_bit", wr_last0, 5'b00010);
        check("wr1_oe", oe_d + oe_h, 0);

        // write 0xAA to addr 4, then read it back
        m0[4] = 8'hAA;
        push_exp(flat0());
        apply_stimulus(0, 32'h84AA, 16, 16, 8, rx, oe_d, oe_h);
        end_frame(0);
        check_output("wr4_regs", regs0);
        check("wr4_stb_bit", wr_last0, 5'b10000);

        push_exp(m0[4]);
        push_exp(flat0());
        apply_stimulus(0, 32'h0400, 16, 16, 8, rx, oe_d, oe_h);
        end_frame(0);
        check_output("rd4_data", rx);
        check("rd4_oe_data", oe_d, 8);
        check("rd4_oe_hdr", oe_h, 0);
        check_output("rd4_regs", regs0);
        check("rd4_oe_after", oe0, 1'b0);
        check("rd4_no_stb", wr_cyc0, 2);

        // write to out-of-range addr 7
        push_exp(flat0());
        apply_stimulus(0, 32'h873C, 16, 16, 8, rx, oe_d, oe_h);
        end_frame(0);
        check_output("wr7_regs", regs0);
        check("wr7_addr_err", ae_cnt0, 1);
        check("wr7_no_stb", wr_cyc0, 2);

        // read out-of-range addr 6 returns zeros
        push_exp(0);
        apply_stimulus(0, 32'h0600, 16, 16, 8, rx, oe_d, oe_h);
        end_frame(0);
        check_output("rd6_data", rx);
        check("rd6_addr_err", ae_cnt0, 2);

        // short frame (12 bits) and overrun frame (17 bits)
        apply_stimulus(0, 32'h8211, 16, 12, 8, rx, oe_d, oe_h);
        end_frame(0);
        check("short_frame_err", fe_cnt0, 1);
        apply_stimulus(0, 32'h8211, 16, 17, 8, rx, oe_d, oe_h);
        end_frame(0);
        check("long_frame_err", fe_cnt0, 2);
        push_exp(flat0());
        check_output("frame_err_regs", regs0);
        check("frame_err_no_stb", wr_cyc0, 2);

        // reset in the middle of a write, then a clean write
        apply_stimulus(0, 32'h80FF, 16, 10, 8, rx, oe_d, oe_h);
        rst = 1'b1;
        wait_clk(3);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) m0[i] = '0;
        push_exp(flat0());
        wait_clk(2);
        check_output("midrst_regs", regs0);
        end_frame(0);
        m0[0] = 8'h55;
        push_exp(flat0());
        apply_stimulus(0, 32'h8055, 16, 16, 8, rx, oe_d, oe_h);
        end_frame(0);
        check_output("post_rst_regs", regs0);
        check("post_rst_stb", wr_last0, 5'b00001);
        check("post_rst_errs", {fe_cnt0[15:0], ae_cnt0[15:0]}, {16'd2, 16'd2});

        // 16x16 instance: write 0xBEEF to addr 15, read it back
        m1_15 = 16'hBEEF;
        push_exp(m1_15);
        apply_stimulus(1, 32'h1FBEEF, 21, 21, 5, rx, oe_d, oe_h);
        end_frame(1);
        check_output("wide_wr_regs", regs1[255:240]);
        check("wide_wr_low", regs1[239:0], '0);
        check("wide_wr_stb", wr_last1, 16'h8000);
        check("wide_wr_cycles", wr_cyc1, 1);

        push_exp(m1_15);
        apply_stimulus(1, 32'h0F0000, 21, 21, 5, rx, oe_d, oe_h);
        end_frame(1);
        check_output("wide_rd_data", rx);
        check("wide_rd_oe", oe_d, 16);
        check("wide_errs", {fe_cnt1[15:0], ae_cnt1[15:0]}, '0);
        check("dut0_idle_during_dut1", regs0, {32'h0, 8'h55});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/spi_reg_bank.md
# spi_reg_bank

Parametrised SPI-mode-0 peripheral with a NUM_REGS × DATA_W register bank, supporting both writes and read-back over CIPO. It sits between the chip's SPI pins and the output/PWM control logic, and replaces the fixed 5 × 8-bit write-only register block. It adds framing-error and address-error reporting, plus per-register write strobes, so consumers can react to updates.

## Interface
Parameters:
- NUM_REGS, 5, number of registers; valid addresses are 0..NUM_REGS-1
- DATA_W, 8, register width in bits
- ADDR_W, 7, address field width; NUM_REGS ≤ 2**ADDR_W
- SYNC_STAGES, 2, synchroniser depth on sclk/copi/ncs (≥2)
- FRAME_W, derived = 1+ADDR_W+DATA_W (16 at defaults); not overridable

Ports:
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- sclk  in  1  SPI clock, asynchronous to clk, idle low
- copi  in  1  SPI data in, asynchronous
- ncs  in  1  SPI chip select, active low, asynchronous
- cipo  out  1  SPI data out, MSB first
- cipo_oe  out  1  cipo output enable; high only in the data phase of a read frame
- regs  out  NUM_REGS*DATA_W  flattened bank; register i at [i*DATA_W +: DATA_W]
- wr_stb  out  NUM_REGS  one-cycle pulse on bit i when register i is committed
- frame_err  out  1  one-cycle pulse when a frame is aborted with a wrong bit count
- addr_err  out  1  one-cycle pulse when a complete frame targets an address ≥ NUM_REGS

## Operation
- Frame format, MSB first: bit FRAME_W-1 = R/W (1 write, 0 read); next ADDR_W bits = address; last DATA_W bits = data.
- copi is sampled on each synchronised sclk rising edge. cipo changes on each synchronised sclk falling edge.
- FSM states: IDLE, HDR, WDATA, RDATA, DONE.
  - IDLE → HDR on the ncs falling edge. Bit counter and shift register clear to 0.
  - HDR → WDATA or RDATA after 1+ADDR_W bits, chosen by the R/W bit.
  - RDATA entry: load the shift-out register with regs[addr], or all zeros if addr ≥ NUM_REGS. Drive cipo_oe=1.
  - WDATA/RDATA → DONE after DATA_W more bits. Further sclk edges in DONE set an overrun flag.
  - Any state except IDLE → IDLE on the ncs rising edge.
- Commit happens on the ncs rising edge, only if the state is DONE and there is no overrun.
  - Write with a valid address: register updates, and wr_stb[addr] pulses.
  - Write with an invalid address: addr_err pulses and no register changes.
  - Read with an invalid address: addr_err pulses; zeros have already been shifted out.
- An ncs rising edge in HDR/WDATA/RDATA, or in DONE with overrun, gives frame_err, and no write occurs.
- An ncs falling edge in any non-IDLE state (glitch) restarts the frame from HDR. The partial frame is discarded silently.
- Event priority within one cycle: rst > ncs edge > sclk edge.
- A read returns the register value as it was at the end of HDR. A write in a later frame never affects a read already in progress.

## Timing
- Reset values: regs all 0; wr_stb, frame_err, addr_err, cipo, cipo_oe all 0; FSM in IDLE; synchronisers 0.
- Input latency: SYNC_STAGES+1 clk cycles from pin to detected edge.
- Required clock ratio: clk ≥ 8× sclk. ncs setup and hold to the first and last sclk edge must each be ≥ 4 clk cycles.
- Write latency: regs and wr_stb update 1 clk cycle after the ncs rising edge is detected. wr_stb is high for exactly 1 cycle.
- Read data timing:
  - The data MSB appears on cipo 1 clk cycle after the sclk falling edge that follows the last address bit is detected.
  - Each subsequent bit follows 1 cycle after each detected falling edge.
  - cipo_oe drops together with the ncs rising edge detection.
- rst asserted mid-frame: the frame is dropped, all outputs go to their reset values on the next edge, and no error pulses are generated.

## Structure
- Shared package spi_pkg:
  - FSM state enum: IDLE, HDR, WDATA, RDATA, DONE.
  - R/W bit encodings WR=1, RD=0.
  - Function computing FRAME_W from ADDR_W and DATA_W.
- One sub-module, spi_sync_edge: SYNC_STAGES-deep synchroniser with registered rise/fall pulse outputs. Instantiated three times, for sclk, copi and ncs; only the level output is used for copi.
- The bank is a flat register array with a single write port; reads use a NUM_REGS:1 mux into the shift-out register.

## Test plan
- Write 0x81_A5 (addr 1, data 0xA5) at defaults → regs[15:8]=0xA5, wr_stb=5'b00010 for 1 cycle, all other registers 0.
- Write 0xAA to addr 4, then read addr 4 (frame 0x04_00) → cipo shifts 10101010 MSB first during the data phase, cipo_oe high for those 8 bits only, no register change.
- Write addr 7 (≥ NUM_REGS) with data 0x3C → addr_err pulses once, regs unchanged, no wr_stb.
- Raise ncs after 12 bits, and separately after 17 bits → frame_err pulses each time, regs unchanged.
- Assert rst after 10 bits of a write to addr 0, release, then send a full write of 0x55 to addr 0 → regs[7:0] is 0 after reset and 0x55 after the second frame, with no error pulses.
- Parameter set NUM_REGS=16, DATA_W=16, ADDR_W=4 (FRAME_W=21): write 0xBEEF to addr 15, then read it back → regs[255:240]=0xBEEF and cipo returns 0xBEEF.
